sti_dac_param: RTL and testbench
================================

STI_DAC_PARAM -- requirements
Module: sti_dac_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16, parallel input width in bits (multiple of 8, 8..32).
REQ-002 SHALL have parameter MAX_BYTES, default 4, maximum serial frame length in bytes (1..8).
REQ-003 SHALL have parameter BANKS, default 4, number of odd/even memory bank pairs.
REQ-004 SHALL have parameter ADDR_W, default 5, per-bank address width.
REQ-005 SHALL have parameter ROW_BYTES, default 8, bytes per image row (power of 2) used for the checkerboard split.
REQ-006 Ports SHALL be as follows:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- load  in  1  frame request, accepted when in_ready=1.
- in_ready  out  1  high only in IDLE.
- pi_data  in  DATA_W  parallel payload.
- pi_length  in  $clog2(MAX_BYTES)  frame length in bytes minus 1.
- pi_fill  in  1  for L>DATA_W: 1=data in MSBs, 0=data in LSBs.
- pi_msb  in  1  1=MSB-first, 0=LSB-first.
- pi_low  in  1  for L<DATA_W: 1=low L bits, 0=high L bits.
- pi_end  in  1  marks the last frame.
- so_data  out  1  serial bit.
- so_valid  out  1  serial bit qualifier.
- oem_dataout  out  8  byte to memory.
- oem_addr  out  ADDR_W  bank word address.
- odd_wr  out  BANKS  one-hot odd-bank write strobe.
- even_wr  out  BANKS  one-hot even-bank write strobe.
- oem_finish  out  1  all memory written; sticky.
- oem_overflow  out  1  sticky; a byte was dropped because capacity was exceeded.

Function
REQ-007 L=8*(pi_length+1) SHALL be computed, and pi_data, pi_length, pi_fill, pi_msb, pi_low and pi_end SHALL be captured on the cycle load&in_ready.
REQ-008 Frame word SHALL be: L<DATA_W: pi_low ? pi_data[L-1:0] : pi_data[DATA_W-1:DATA_W-L]; L=DATA_W: pi_data; L>DATA_W: pi_fill ? {pi_data, zeros} : {zeros, pi_data}.
REQ-009 FSM states SHALL be IDLE, SHIFT, PAD, DONE.
- IDLE->SHIFT on accepted load.
- SHIFT->IDLE after L bits when end=0.
- SHIFT->PAD after L bits when end=1.
- PAD->DONE when capacity is written.
- DONE holds until reset.
REQ-010 so_valid SHALL be high for exactly L consecutive cycles, starting the cycle after accept; so_data SHALL be frame bit L-1 downward (pi_msb=1) or bit 0 upward (pi_msb=0).
REQ-011 Load SHALL be ignored when in_ready=0; back-to-back frames SHALL have at most 1 idle cycle between so_valid bursts.
REQ-012 Deserializer SHALL shift so_data in, first bit into oem_dataout[7]; after every 8th valid bit it SHALL pulse exactly one strobe for one cycle, in the cycle after that bit, with oem_dataout and oem_addr stable in that cycle.
REQ-013 Global byte index k (capacity C=BANKS*2^(ADDR_W+1)) SHALL persist across frames.
- bank=k>>(ADDR_W+1)
- j=k mod 2^(ADDR_W+1)
- oem_addr=j>>1
- parity=j[0]^((j/ROW_BYTES)&1)
- parity=0 -> even_wr[bank]; parity=1 -> odd_wr[bank].
REQ-014 In PAD, 0x00 bytes SHALL be written one per cycle at successive k until k=C; if k=C already, PAD SHALL last 1 cycle.
REQ-015 oem_finish SHALL rise the cycle after the last write of PAD (or after entering PAD when k=C) and SHALL hold.
REQ-016 Bytes arriving with k=C SHALL be dropped with no strobe, and oem_overflow SHALL set.
REQ-017 All strobes SHALL be zero in every cycle without a byte write; at most one strobe bit SHALL be high per cycle.

Reset
REQ-018 On reset the block SHALL take the following values:
- state=IDLE, k=0, shift registers=0.
- so_data=0, so_valid=0.
- oem_dataout=0, oem_addr=0.
- odd_wr=0, even_wr=0.
- oem_finish=0, oem_overflow=0.
- in_ready=1 from the first clock after release.
REQ-019 Reset mid-frame SHALL abort the frame immediately; no strobe SHALL be produced for partial bytes.

Structure
REQ-020 Package sti_dac_pkg SHALL hold the FSM state enum, the L-decode and frame-build functions, and the byte-index-to-bank/addr/parity function.
REQ-021 Sub-module sti_dac_deser SHALL implement byte assembly, index k, strobe decode, PAD generation and overflow; the top SHALL hold the STI FSM and shifter.

Verification
REQ-022 Scenario: DATA_W=16, pi_length=0, pi_low=1, pi_msb=1, pi_data=0x12A5 -> so_data 1,0,1,0,0,1,0,1 with so_valid for 8 cycles; even_wr[0] pulse with addr=0 and data 0xA5.
REQ-023 Scenario: pi_length=3, pi_fill=0, pi_msb=0, pi_data=0x8001 -> 32 valid bits, first bit 1, bit 15 is 1, rest 0; bytes 0x80,0x01,0x00,0x00 written.
REQ-024 Scenario: 8 frames of 2 bytes -> k=0..15 with strobe sequence even,odd (x4) for row 0, then odd,even (x4) for row 1; addr 0,0,1,1,...,7,7.
REQ-025 Scenario: pi_end=1 on the first 1-byte frame -> 255 PAD writes of 0x00 covering banks 0..3; oem_finish=1 the cycle after k reaches 256.
REQ-026 Scenario: 257 bytes sent with the final frame pi_end=1 -> byte 257 is not written, oem_overflow=1, oem_finish=1.
REQ-027 Scenario: reset asserted after bit 5 of a 16-bit frame -> no strobe and all outputs 0; the next load is accepted normally.

Source files
------------

// File: rtl/sti_dac_pkg.sv
// Shared types and pure helpers for the STI serializer and DAC memory writer.
package sti_dac_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PAD, ST_DONE} sti_state_e;

    localparam int MAX_FRAME_W = 64;

    typedef logic [MAX_FRAME_W-1:0] frame_t;

    typedef struct packed {
        logic [7:0]  bank;
        logic [15:0] addr;
        logic        parity;
    } slot_t;

    function automatic int frame_bits(input int length);
        return 8 * (length + 1);
    endfunction

    function automatic frame_t low_mask(input int n);
        frame_t m;
        m = '0;
        for (int i = 0; i < MAX_FRAME_W; i++) m[i] = (i < n);
        return m;
    endfunction

    // Truncate, pass through or pad the payload to an l-bit frame word.
    function automatic frame_t build_frame(input logic [31:0] data, input int data_w,
                                           input int l, input logic fill, input logic low);
        frame_t d;
        d = frame_t'(data) & low_mask(data_w);
        if (l < data_w) return low ? (d & low_mask(l)) : (d >> (data_w - l));
        if (l == data_w) return d;
        return fill ? (d << (l - data_w)) : d;
    endfunction

    // Checkerboard split: parity flips every image row so adjacent rows alternate banks.
    function automatic slot_t map_index(input int k, input int addr_w, input int row_bytes);
        slot_t s;
        int    j;
        j        = k % (1 << (addr_w + 1));
        s.bank   = 8'(k >> (addr_w + 1));
        s.addr   = 16'(j >> 1);
        s.parity = 1'(j) ^ 1'(j / row_bytes);
        return s;
    endfunction

endpackage

// File: rtl/sti_dac_param_if.sv
// Memory-write bus between the deserializer (master) and its consumer (slave).
interface sti_dac_param_if #(
    parameter int BANKS  = 4,
    parameter int ADDR_W = 5
);
    logic [7:0]        oem_dataout;
    logic [ADDR_W-1:0] oem_addr;
    logic [BANKS-1:0]  odd_wr;
    logic [BANKS-1:0]  even_wr;
    logic              oem_finish;
    logic              oem_overflow;

    modport master (output oem_dataout, oem_addr, odd_wr, even_wr, oem_finish, oem_overflow);
    modport slave  (input  oem_dataout, oem_addr, odd_wr, even_wr, oem_finish, oem_overflow);
endinterface

// File: rtl/sti_dac_deser.sv
// Byte assembly from the serial stream, global byte index, bank strobe decode,
// zero padding to capacity and overflow tracking.
module sti_dac_deser
    import sti_dac_pkg::*;
#(
    parameter int BANKS     = 4,
    parameter int ADDR_W    = 5,
    parameter int ROW_BYTES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic bit_data,
    input  logic bit_valid,
    input  logic pad,
    output logic cap_full,
    sti_dac_param_if.master mem
);
    localparam int CAP = BANKS * (2 ** (ADDR_W + 1));
    localparam int K_W = $clog2(CAP + 1);

    logic [6:0]     sr;
    logic [2:0]     bit_cnt;
    logic [K_W-1:0] k;
    logic           byte_done;
    logic           wr_en;
    logic [7:0]     wr_byte;
    slot_t          slot;

    assign cap_full  = (k == K_W'(CAP));
    assign byte_done = bit_valid && (bit_cnt == 3'd7);
    assign slot      = map_index(int'(k), ADDR_W, ROW_BYTES);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_en   = 1'b0;
        wr_byte = 8'h00;
        if (byte_done) begin
            wr_en   = !cap_full;
            wr_byte = {sr, bit_data};
        end else if (pad) begin
            wr_en = !cap_full;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr               <= '0;
            bit_cnt          <= '0;
            k                <= '0;
            mem.oem_dataout  <= '0;
            mem.oem_addr     <= '0;
            mem.odd_wr       <= '0;
            mem.even_wr      <= '0;
            mem.oem_finish   <= 1'b0;
            mem.oem_overflow <= 1'b0;
        end else begin
            mem.odd_wr  <= '0;
            mem.even_wr <= '0;
            if (bit_valid) begin
                sr      <= {sr[5:0], bit_data};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (wr_en) begin
                k               <= k + K_W'(1);
                mem.oem_dataout <= wr_byte;
                mem.oem_addr    <= ADDR_W'(slot.addr);
                if (slot.parity) mem.odd_wr  <= BANKS'(1) << slot.bank;
                else             mem.even_wr <= BANKS'(1) << slot.bank;
            end
            if (byte_done && cap_full) mem.oem_overflow <= 1'b1;
            if (pad && cap_full)       mem.oem_finish   <= 1'b1;
        end
    end

endmodule

// File: rtl/sti_dac_param.sv
// STI parallel-to-serial converter feeding a checkerboard DAC memory writer.
module sti_dac_param
    import sti_dac_pkg::*;
#(
    parameter  int DATA_W    = 16,
    parameter  int MAX_BYTES = 4,
    parameter  int BANKS     = 4,
    parameter  int ADDR_W    = 5,
    parameter  int ROW_BYTES = 8,
    localparam int LEN_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    output logic              in_ready,
    input  logic [DATA_W-1:0] pi_data,
    input  logic [LEN_W-1:0]  pi_length,
    input  logic              pi_fill,
    input  logic              pi_msb,
    input  logic              pi_low,
    input  logic              pi_end,
    output logic              so_data,
    output logic              so_valid,
    output logic [7:0]        oem_dataout,
    output logic [ADDR_W-1:0] oem_addr,
    output logic [BANKS-1:0]  odd_wr,
    output logic [BANKS-1:0]  even_wr,
    output logic              oem_finish,
    output logic              oem_overflow
);
    localparam int FRAME_W = 8 * MAX_BYTES;
    localparam int CNT_W   = $clog2(FRAME_W);

    sti_state_e         state, next_state;
    logic [FRAME_W-1:0] shreg;
    logic [FRAME_W-1:0] frame_load;
    logic [CNT_W-1:0]   bit_cnt, last_bit;
    logic               msb_q, end_q, accept, cap_full;
    int                 load_bits;

    sti_dac_param_if #(.BANKS(BANKS), .ADDR_W(ADDR_W)) mem ();

    // MSB-first frames are left-aligned so both orders shift out of a fixed end.
    always_comb begin
        load_bits = frame_bits(int'(pi_length));
        if (load_bits > FRAME_W) load_bits = FRAME_W;
        frame_load = FRAME_W'(build_frame(32'(pi_data), DATA_W, load_bits, pi_fill, pi_low));
        if (pi_msb) frame_load = frame_load << (FRAME_W - load_bits);
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: if (load) begin
                accept     = 1'b1;
                next_state = ST_SHIFT;
            end
            ST_SHIFT: if (bit_cnt == last_bit) next_state = end_q ? ST_PAD : ST_IDLE;
            ST_PAD:   if (cap_full) next_state = ST_DONE;
            ST_DONE:  next_state = ST_DONE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            last_bit <= '0;
            msb_q    <= 1'b0;
            end_q    <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                shreg    <= frame_load;
                bit_cnt  <= '0;
                last_bit <= CNT_W'(load_bits - 1);
                msb_q    <= pi_msb;
                end_q    <= pi_end;
            end else if (state == ST_SHIFT) begin
                shreg   <= msb_q ? (shreg << 1) : (shreg >> 1);
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready = (state == ST_IDLE);
    assign so_valid = (state == ST_SHIFT);
    assign so_data  = so_valid & (msb_q ? shreg[FRAME_W-1] : shreg[0]);

    sti_dac_deser #(
        .BANKS    (BANKS),
        .ADDR_W   (ADDR_W),
        .ROW_BYTES(ROW_BYTES)
    ) u_deser (
        .clk      (clk),
        .reset    (reset),
        .bit_data (so_data),
        .bit_valid(so_valid),
        .pad      (state == ST_PAD),
        .cap_full (cap_full),
        .mem      (mem)
    );

    assign oem_dataout  = mem.oem_dataout;
    assign oem_addr     = mem.oem_addr;
    assign odd_wr       = mem.odd_wr;
    assign even_wr      = mem.even_wr;
    assign oem_finish   = mem.oem_finish;
    assign oem_overflow = mem.oem_overflow;

endmodule

// File: tb/tb_sti_dac_param.sv
// Scoreboard bench for sti_dac_param: serial bits and memory writes are predicted
// from a frame/byte-index model and checked by independent monitors.
module tb_sti_dac_param;
    localparam int DATA_W    = 16;
    localparam int MAX_BYTES = 4;
    localparam int BANKS     = 4;
    localparam int ADDR_W    = 5;
    localparam int ROW_BYTES = 8;
    localparam int BANK_SZ   = 1 << (ADDR_W + 1);
    localparam int CAP       = BANKS * BANK_SZ;

    typedef struct packed {
        logic [BANKS-1:0]  odd;
        logic [BANKS-1:0]  even;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset, load, in_ready;
    logic [DATA_W-1:0] pi_data;
    logic [1:0]        pi_length;
    logic              pi_fill, pi_msb, pi_low, pi_end;
    logic              so_data, so_valid;

    sti_dac_param_if #(.BANKS(BANKS), .ADDR_W(ADDR_W)) mem_if ();

    sti_dac_param #(
        .DATA_W(DATA_W), .MAX_BYTES(MAX_BYTES), .BANKS(BANKS),
        .ADDR_W(ADDR_W), .ROW_BYTES(ROW_BYTES)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .in_ready(in_ready),
        .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill),
        .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
        .so_data(so_data), .so_valid(so_valid),
        .oem_dataout(mem_if.oem_dataout), .oem_addr(mem_if.oem_addr),
        .odd_wr(mem_if.odd_wr), .even_wr(mem_if.even_wr),
        .oem_finish(mem_if.oem_finish), .oem_overflow(mem_if.oem_overflow)
    );

    always #5 clk = ~clk;

    int  n_tests = 0, n_fail = 0;
    int  cyc = 0, last_wr_cyc = 0, mk = 0;
    bit  exp_overflow = 1'b0;
    bit  exp_bits[$];
    wr_t exp_wr[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint unsigned model_frame(input int unsigned data, input int len,
                                                    input bit fill, input bit low);
        int nbits;
        longint unsigned d;
        nbits = 8 * (len + 1);
        d = longint'(data % 65536);
        if (nbits < DATA_W) return low ? d % (64'd1 << nbits) : d / (64'd1 << (DATA_W - nbits));
        if (nbits == DATA_W) return d;
        return fill ? d * (64'd1 << (nbits - DATA_W)) : d;
    endfunction

    task automatic push_byte(input int b);
        int  j, bank;
        wr_t w;
        if (mk >= CAP) begin
            exp_overflow = 1'b1;
            return;
        end
        bank   = mk / BANK_SZ;
        j      = mk % BANK_SZ;
        w.odd  = '0;
        w.even = '0;
        if (((j % 2) + (j / ROW_BYTES)) % 2 == 1) w.odd  = BANKS'(1) << bank;
        else                                      w.even = BANKS'(1) << bank;
        w.addr = ADDR_W'(j / 2);
        w.data = 8'(b);
        exp_wr.push_back(w);
        mk++;
    endtask

    task automatic push_frame(input longint unsigned frame, input int nbits, input bit msb,
                              input bit bytes);
        int acc, pos;
        bit b;
        acc = 0;
        for (int i = 0; i < nbits; i++) begin
            pos = msb ? (nbits - 1 - i) : i;
            b   = ((frame >> pos) & 64'd1) != 0;
            exp_bits.push_back(b);
            acc = (acc * 2 + int'(b)) % 256;
            if (bytes && (i % 8 == 7)) push_byte(acc);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (so_valid === 1'b1) begin
            if (exp_bits.size() == 0) check("unexpected_bit", so_valid, 0);
            else check("so_data", so_data, exp_bits.pop_front());
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0 && ((|mem_if.odd_wr) || (|mem_if.even_wr))) begin
            last_wr_cyc = cyc;
            if (exp_wr.size() == 0)
                check("unexpected_write", {mem_if.odd_wr, mem_if.even_wr}, 0);
            else
                check("mem_write", {mem_if.odd_wr, mem_if.even_wr, mem_if.oem_addr,
                                    mem_if.oem_dataout}, exp_wr.pop_front());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic scramble();
        pi_data   = DATA_W'($urandom);
        pi_length = 2'($urandom);
        pi_fill   = 1'($urandom);
        pi_msb    = 1'($urandom);
        pi_low    = 1'($urandom);
        pi_end    = 1'($urandom);
    endtask

    task automatic check_reset_values();
        check("rst_so_data", so_data, 0);
        check("rst_so_valid", so_valid, 0);
        check("rst_dataout", mem_if.oem_dataout, 0);
        check("rst_addr", mem_if.oem_addr, 0);
        check("rst_odd_wr", mem_if.odd_wr, 0);
        check("rst_even_wr", mem_if.even_wr, 0);
        check("rst_finish", mem_if.oem_finish, 0);
        check("rst_overflow", mem_if.oem_overflow, 0);
        check("rst_in_ready", in_ready, 1);
    endtask

    // Called and returns at a falling edge.
    task automatic do_reset();
        check("bits_drained", exp_bits.size(), 0);
        check("writes_drained", exp_wr.size(), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        exp_bits.delete();
        exp_wr.delete();
        mk = 0;
        exp_overflow = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_reset_values();
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] data, input int len, input bit fill,
                              input bit msb, input bit low, input bit endf);
        int nbits, cnt;
        nbits = 8 * (len + 1);
        check("in_ready_before_load", in_ready, 1);
        load = 1'b1; pi_data = data; pi_length = 2'(len);
        pi_fill = fill; pi_msb = msb; pi_low = low; pi_end = endf;
        push_frame(model_frame(int'(data), len, fill, low), nbits, msb, 1'b1);
        if (endf) while (mk < CAP) push_byte(0);
        @(negedge clk);
        load = 1'b0;
        scramble();
        cnt = 0;
        while (so_valid === 1'b1 && cnt < 80) begin
            cnt++;
            load = (cnt < nbits) ? 1'($urandom_range(0, 1)) : 1'b0;
            scramble();
            @(negedge clk);
        end
        load = 1'b0;
        check("burst_len", cnt, nbits);
        if (!endf) check("in_ready_after_burst", in_ready, 1);
    endtask

    task automatic wait_finish(input bit timing);
        int n;
        n = 0;
        while (mem_if.oem_finish !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("finish_seen", mem_if.oem_finish, 1);
        if (timing) check("finish_latency", cyc - last_wr_cyc, 1);
        check("overflow_flag", mem_if.oem_overflow, exp_overflow);
        check("in_ready_in_done", in_ready, 0);
        check("writes_done", exp_wr.size(), 0);
        repeat (3) @(negedge clk);
        check("finish_sticky", mem_if.oem_finish, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset = 1'b1; load = 1'b0;
        pi_data = '0; pi_length = '0; pi_fill = 0; pi_msb = 0; pi_low = 0; pi_end = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values();

        // Single-byte and four-byte directed frames.
        send_frame(16'h12A5, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(16'h8001, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // Checkerboard walk over two rows, then random traffic and padding.
        do_reset();
        for (int i = 0; i < 8; i++)
            send_frame(DATA_W'($urandom), 1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        for (int i = 0; i < 30; i++)
            send_frame(DATA_W'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                       1'($urandom), 1'b0);
        send_frame(DATA_W'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'b1);
        wait_finish(1'b1);

        // First frame marked last: 255 padding bytes.
        do_reset();
        send_frame(DATA_W'($urandom), 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        wait_finish(1'b1);

        // 257 bytes: the last one must be dropped.
        do_reset();
        for (int i = 0; i < 64; i++)
            send_frame(DATA_W'($urandom), 3, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        send_frame(DATA_W'($urandom), 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        wait_finish(1'b0);

        // Reset after five bits of a 16-bit frame.
        do_reset();
        load = 1'b1; pi_data = DATA_W'($urandom); pi_length = 2'd1;
        pi_fill = 1'($urandom); pi_msb = 1'($urandom); pi_low = 1'($urandom); pi_end = 1'b0;
        push_frame(model_frame(int'(pi_data), 1, pi_fill, pi_low), 16, pi_msb, 1'b0);
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_valid_before_reset", so_valid, 1);
        #1 reset = 1'b1;
        @(negedge clk);
        check_reset_values();
        exp_bits.delete();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        send_frame(DATA_W'($urandom), 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        repeat (3) @(negedge clk);
        check("post_reset_writes", exp_wr.size(), 0);
        check("post_reset_bits", exp_bits.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d",
                 n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
